// File: rtl/data_mem_bridge_if.sv
// data_mem_bridge_if
// Handshaked bus between the data-memory bridge and the slow data RAM.
//   bus_req   : request held high while an access is outstanding
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : word-aligned byte address
//   bus_wdata : write data
//   bus_ack   : one-cycle completion strobe from the RAM
//   bus_rdata : read data, valid while bus_ack is high
//   bus_err   : one-cycle pulse when the bridge abandons a hung access
// The bridge uses the master modport, the RAM (or its model) the slave modport.
interface data_mem_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_err,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_err,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/data_mem_bridge.sv
// data_mem_bridge
// Multi-cycle bridge from the core's MEM-stage data port to a slow handshaked
// RAM. An IDLE/BUSY/DONE FSM issues one request per access, stalls the core
// until the RAM acknowledges, and a watchdog abandons an access that is not
// acknowledged within TIMEOUT busy cycles, pulsing bus_err.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ram_cs              : core selects the data RAM this cycle
//   mem_ren, mem_wen    : core read / write request (both high = write)
//   mem_addr, mem_dout  : core byte address and write data
//   mem_din             : registered read data back to the core
//   ram_stall           : combinational stall to the core pipeline
//   bus                 : RAM-side handshake (data_mem_bridge_if.master)
module data_mem_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_cs,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        ram_stall,
    data_mem_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value on the last busy cycle the watchdog allows.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             req_r, req_s;
    logic             we_r, we_s;
    logic [31:0]      addr_r, addr_s;
    logic [31:0]      wdata_r, wdata_s;
    logic             err_r, err_s;
    logic [31:0]      din_r, din_s;
    logic             acc_s;

    assign acc_s = ram_cs & (mem_ren | mem_wen);

    // Next-state and next-output logic; every register holds unless updated.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        req_s   = req_r;
        we_s    = we_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        err_s   = 1'b0;
        din_s   = din_r;
        case (state_r)
            IDLE: begin
                if (acc_s) begin
                    // Write wins when both requests are high; low address
                    // bits are masked off to form the word address.
                    addr_s  = mem_addr & 32'hFFFF_FFFC;
                    wdata_s = mem_dout;
                    we_s    = mem_wen;
                    req_s   = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                // Ack takes priority over the watchdog in the same cycle.
                if (bus.bus_ack) begin
                    req_s   = 1'b0;
                    state_s = DONE;
                    if (!we_r) begin
                        din_s = bus.bus_rdata;
                    end else begin
                        din_s = din_r;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    req_s   = 1'b0;
                    err_s   = 1'b1;
                    state_s = DONE;
                    if (!we_r) begin
                        din_s = ERR_DATA;
                    end else begin
                        din_s = din_r;
                    end
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                    state_s = BUSY;
                end
            end
            DONE: begin
                // The core advances on this edge; a new access is only
                // sampled once back in IDLE.
                state_s = IDLE;
            end
            default: begin
                req_s   = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
            din_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            req_r   <= req_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            err_r   <= err_s;
            din_r   <= din_s;
        end
    end

    // Stall is combinational in IDLE so the core cannot slip past a fresh
    // access before the request has been registered.
    assign ram_stall     = ((state_r == IDLE) & acc_s) | (state_r == BUSY);
    assign mem_din       = din_r;
    assign bus.bus_req   = req_r;
    assign bus.bus_we    = we_r;
    assign bus.bus_addr  = addr_r;
    assign bus.bus_wdata = wdata_r;
    assign bus.bus_err   = err_r;

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge
// Directed bench: a per-cycle vector table on a default-timeout instance
// (reset, immediate-ack read, 5-cycle write, read+write collision, stray
// acks) followed by hand-written sequences for reset during BUSY and, on a
// TIMEOUT=4 instance, watchdog expiry and ack/timeout coincidence.
module tb_data_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_cs;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] din_a, din_b;
    logic        stall_a, stall_b;

    int n_vec  = 0;
    int n_fail = 0;

    localparam logic [31:0] ERR_B = 32'hBAD0_BAD0;

    data_mem_bridge_if if_a ();
    data_mem_bridge_if if_b ();

    data_mem_bridge dut_a (
        .clk      (clk),
        .rst      (rst),
        .ram_cs   (ram_cs),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_din  (din_a),
        .ram_stall(stall_a),
        .bus      (if_a)
    );

    data_mem_bridge #(.TIMEOUT(4), .CNT_W(8), .ERR_DATA(ERR_B)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .ram_cs   (ram_cs),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_din  (din_b),
        .ram_stall(stall_b),
        .bus      (if_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cs;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] dout;
        logic        ack;
        logic [31:0] rdata;
        logic        x_stall;
        logic        x_req;
        logic        x_we;
        logic [31:0] x_addr;
        logic [31:0] x_wdata;
        logic        x_err;
        logic [31:0] x_din;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic cs, input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] dout);
        rst      = r;
        ram_cs   = cs;
        mem_ren  = ren;
        mem_wen  = wen;
        mem_addr = addr;
        mem_dout = dout;
    endtask

    initial begin
        //            rst   cs    ren   wen   addr          dout          ack   rdata        | stall req   we    addr          wdata         err   din
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1006, 32'h0,        1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1006, 32'h0,        1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1006, 32'h0,        1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1006, 32'h0,        1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, 32'h0000_1004, 32'h0,         1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1006, 32'h0,        1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 32'h0000_1004, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2008, 32'h1234_5678, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0000_1004, 32'h0,         1'b0, 32'hCAFE_F00D};
        for (int i = 6; i <= 9; i++) begin
            tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2008, 32'h1234_5678, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h0000_2008, 32'h1234_5678, 1'b0, 32'hCAFE_F00D};
        end
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2008, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'h0000_2008, 32'h1234_5678, 1'b0, 32'hCAFE_F00D};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2008, 32'h1234_5678, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_2008, 32'h1234_5678, 1'b0, 32'hCAFE_F00D};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 32'h0000_2008, 32'h1234_5678, 1'b0, 32'hCAFE_F00D};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_2008, 32'h1234_5678, 1'b0, 32'hCAFE_F00D};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_300F, 32'hA5A5_5A5A, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0000_2008, 32'h1234_5678, 1'b0, 32'hCAFE_F00D};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_300F, 32'hA5A5_5A5A, 1'b1, 32'h7777_7777, 1'b1, 1'b1, 1'b1, 32'h0000_300C, 32'hA5A5_5A5A, 1'b0, 32'hCAFE_F00D};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'h0000_300C, 32'hA5A5_5A5A, 1'b0, 32'hCAFE_F00D};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_300C, 32'hA5A5_5A5A, 1'b0, 32'hCAFE_F00D};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        if_a.bus_ack   = 1'b0;
        if_a.bus_rdata = 32'h0;
        if_b.bus_ack   = 1'b0;
        if_b.bus_rdata = 32'h0;
        repeat (2) @(posedge clk);

        // Table: one record per clock on instance A.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].cs, tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].dout);
            if_a.bus_ack   = tbl[i].ack;
            if_a.bus_rdata = tbl[i].rdata;
            #1;
            chk($sformatf("v%0d stall", i), {31'd0, stall_a},          {31'd0, tbl[i].x_stall});
            chk($sformatf("v%0d req", i),   {31'd0, if_a.bus_req},     {31'd0, tbl[i].x_req});
            chk($sformatf("v%0d we", i),    {31'd0, if_a.bus_we},      {31'd0, tbl[i].x_we});
            chk($sformatf("v%0d addr", i),  if_a.bus_addr,             tbl[i].x_addr);
            chk($sformatf("v%0d wdata", i), if_a.bus_wdata,            tbl[i].x_wdata);
            chk($sformatf("v%0d err", i),   {31'd0, if_a.bus_err},     {31'd0, tbl[i].x_err});
            chk($sformatf("v%0d din", i),   din_a,                     tbl[i].x_din);
        end

        // Reset in BUSY cycle 2 on instance A, then a stray ack in IDLE.
        @(negedge clk);
        if_a.bus_ack = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        #1 chk("rb accept stall", {31'd0, stall_a}, 32'd1);
        @(negedge clk);
        #1 chk("rb busy1 req", {31'd0, if_a.bus_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rb busy2 req", {31'd0, if_a.bus_req}, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        if_a.bus_ack   = 1'b1;
        if_a.bus_rdata = 32'hFEED_FACE;
        #1;
        chk("rb req dropped", {31'd0, if_a.bus_req}, 32'd0);
        chk("rb no err",      {31'd0, if_a.bus_err}, 32'd0);
        chk("rb din cleared", din_a, 32'h0);
        chk("rb stall idle",  {31'd0, stall_a}, 32'd0);
        @(negedge clk);
        if_a.bus_ack = 1'b0;
        #1;
        chk("rb stray ack din", din_a, 32'h0);
        chk("rb stray ack err", {31'd0, if_a.bus_err}, 32'd0);
        chk("rb stray ack req", {31'd0, if_a.bus_req}, 32'd0);

        // Watchdog expiry on instance B (TIMEOUT=4).
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        if_b.bus_ack = 1'b0;
        #1 chk("to accept stall", {31'd0, stall_b}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to busy%0d req", k),   {31'd0, if_b.bus_req}, 32'd1);
            chk($sformatf("to busy%0d stall", k), {31'd0, stall_b},      32'd1);
            chk($sformatf("to busy%0d err", k),   {31'd0, if_b.bus_err}, 32'd0);
        end
        @(negedge clk);
        #1;
        chk("to done req",   {31'd0, if_b.bus_req}, 32'd0);
        chk("to done err",   {31'd0, if_b.bus_err}, 32'd1);
        chk("to done din",   din_b, ERR_B);
        chk("to done stall", {31'd0, stall_b}, 32'd0);

        // Back in IDLE: a new read stalls at once; it then gets its ack in
        // the same cycle the watchdog would fire.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        #1;
        chk("co idle stall", {31'd0, stall_b}, 32'd1);
        chk("co err single", {31'd0, if_b.bus_err}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) begin
                if_b.bus_ack   = 1'b1;
                if_b.bus_rdata = 32'h600D_D00D;
            end
            #1 chk($sformatf("co busy%0d req", k), {31'd0, if_b.bus_req}, 32'd1);
        end
        @(negedge clk);
        if_b.bus_ack = 1'b0;
        #1;
        chk("co done err", {31'd0, if_b.bus_err}, 32'd0);
        chk("co done din", din_b, 32'h600D_D00D);
        chk("co done req", {31'd0, if_b.bus_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
